// File: rtl/ariane_axi_burst_splitter.sv
// Splits AXI4 bursts into single-beat transactions and merges the responses
// back into one burst-shaped response per upstream request.
module ariane_axi_burst_splitter #(
  parameter int unsigned AXI_ADDRESS_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH    = 64,
  parameter int unsigned AXI_ID_WIDTH      = 4,
  parameter int unsigned AXI_USER_WIDTH    = 1,
  parameter int unsigned ATTR_WIDTH        = 16 + AXI_USER_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          s_aw_valid,
  output logic                          s_aw_ready,
  input  logic [AXI_ID_WIDTH-1:0]       s_aw_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  s_aw_addr,
  input  logic [7:0]                    s_aw_len,
  input  logic [2:0]                    s_aw_size,
  input  logic [1:0]                    s_aw_burst,
  input  logic [5:0]                    s_aw_atop,
  input  logic [ATTR_WIDTH-1:0]         s_aw_attr,
  input  logic                          s_w_valid,
  output logic                          s_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_w_strb,
  input  logic                          s_w_last,
  output logic                          s_b_valid,
  input  logic                          s_b_ready,
  output logic [AXI_ID_WIDTH-1:0]       s_b_id,
  output logic [1:0]                    s_b_resp,
  input  logic                          s_ar_valid,
  output logic                          s_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]       s_ar_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  s_ar_addr,
  input  logic [7:0]                    s_ar_len,
  input  logic [2:0]                    s_ar_size,
  input  logic [1:0]                    s_ar_burst,
  input  logic [ATTR_WIDTH-1:0]         s_ar_attr,
  output logic                          s_r_valid,
  input  logic                          s_r_ready,
  output logic [AXI_ID_WIDTH-1:0]       s_r_id,
  output logic [AXI_DATA_WIDTH-1:0]     s_r_data,
  output logic [1:0]                    s_r_resp,
  output logic                          s_r_last,
  output logic                          m_aw_valid,
  input  logic                          m_aw_ready,
  output logic [AXI_ID_WIDTH-1:0]       m_aw_id,
  output logic [AXI_ADDRESS_WIDTH-1:0]  m_aw_addr,
  output logic [7:0]                    m_aw_len,
  output logic [2:0]                    m_aw_size,
  output logic [1:0]                    m_aw_burst,
  output logic [5:0]                    m_aw_atop,
  output logic [ATTR_WIDTH-1:0]         m_aw_attr,
  output logic                          m_w_valid,
  input  logic                          m_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]     m_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_w_strb,
  output logic                          m_w_last,
  input  logic                          m_b_valid,
  output logic                          m_b_ready,
  input  logic [AXI_ID_WIDTH-1:0]       m_b_id,
  input  logic [1:0]                    m_b_resp,
  output logic                          m_ar_valid,
  input  logic                          m_ar_ready,
  output logic [AXI_ID_WIDTH-1:0]       m_ar_id,
  output logic [AXI_ADDRESS_WIDTH-1:0]  m_ar_addr,
  output logic [7:0]                    m_ar_len,
  output logic [2:0]                    m_ar_size,
  output logic [1:0]                    m_ar_burst,
  output logic [ATTR_WIDTH-1:0]         m_ar_attr,
  input  logic                          m_r_valid,
  output logic                          m_r_ready,
  input  logic [AXI_ID_WIDTH-1:0]       m_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]     m_r_data,
  input  logic [1:0]                    m_r_resp,
  input  logic                          m_r_last
);

  typedef logic [AXI_ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [AXI_ID_WIDTH-1:0]      id_t;
  typedef logic [ATTR_WIDTH-1:0]        attr_t;

  typedef enum logic [2:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRSP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_ADDR, R_DATA
  } r_state_t;

  // Address of the beat following cur; reserved burst type behaves as INCR.
  function automatic addr_t next_addr(
    input addr_t      cur,
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    addr_t sz;
    addr_t wsz;
    addr_t bnd;
    sz  = addr_t'(1) << size;
    wsz = (addr_t'(len) + addr_t'(1)) << size;
    bnd = cur & ~(wsz - addr_t'(1));
    unique case (burst)
      2'b00:   next_addr = cur;
      2'b10:   next_addr = bnd + ((cur + sz - bnd) & (wsz - addr_t'(1)));
      default: next_addr = (cur & ~(sz - addr_t'(1))) + sz;
    endcase
  endfunction

  w_state_t   w_state;
  w_state_t   w_next;
  id_t        aw_id_q;
  addr_t      aw_cur_q;
  logic [7:0] aw_len_q;
  logic [2:0] aw_size_q;
  logic [1:0] aw_burst_q;
  logic [5:0] aw_atop_q;
  attr_t      aw_attr_q;
  logic [7:0] w_cnt;
  logic [1:0] w_acc;

  r_state_t   r_state;
  r_state_t   r_next;
  id_t        ar_id_q;
  addr_t      ar_cur_q;
  logic [7:0] ar_len_q;
  logic [2:0] ar_size_q;
  logic [1:0] ar_burst_q;
  attr_t      ar_attr_q;
  logic [7:0] r_cnt;

  logic w_last_beat;
  logic r_last_beat;
  logic unused_ok;

  assign w_last_beat = (w_cnt == aw_len_q);
  assign r_last_beat = (r_cnt == ar_len_q);
  assign unused_ok   = ^{s_w_last, m_b_id, m_r_id, m_r_last};

  always_comb begin
    w_next     = w_state;
    s_aw_ready = 1'b0;
    m_aw_valid = 1'b0;
    s_w_ready  = 1'b0;
    m_w_valid  = 1'b0;
    m_b_ready  = 1'b0;
    s_b_valid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_aw_ready = 1'b1;
        if (s_aw_valid) w_next = W_ADDR;
      end
      W_ADDR: begin
        m_aw_valid = 1'b1;
        if (m_aw_ready) w_next = W_DATA;
      end
      W_DATA: begin
        m_w_valid = s_w_valid;
        s_w_ready = m_w_ready;
        if (s_w_valid && m_w_ready) w_next = W_RESP;
      end
      W_RESP: begin
        m_b_ready = 1'b1;
        if (m_b_valid) w_next = w_last_beat ? W_BRSP : W_ADDR;
      end
      W_BRSP: begin
        s_b_valid = 1'b1;
        if (s_b_ready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state    <= W_IDLE;
      aw_id_q    <= '0;
      aw_cur_q   <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_atop_q  <= '0;
      aw_attr_q  <= '0;
      w_cnt      <= '0;
      w_acc      <= 2'b00;
    end else begin
      w_state <= w_next;
      if (s_aw_valid && s_aw_ready) begin
        aw_id_q    <= s_aw_id;
        aw_cur_q   <= s_aw_addr;
        aw_len_q   <= s_aw_len;
        aw_size_q  <= s_aw_size;
        aw_burst_q <= s_aw_burst;
        aw_atop_q  <= s_aw_atop;
        aw_attr_q  <= s_aw_attr;
        w_cnt      <= '0;
      end
      // First non-OKAY sub-response is the one reported upstream.
      if (m_b_valid && m_b_ready) begin
        if (w_acc == 2'b00) w_acc <= m_b_resp;
        if (!w_last_beat) begin
          w_cnt    <= w_cnt + 8'd1;
          aw_cur_q <= next_addr(aw_cur_q, aw_len_q, aw_size_q, aw_burst_q);
        end
      end
      if (s_b_valid && s_b_ready) w_acc <= 2'b00;
    end
  end

  assign m_aw_id    = aw_id_q;
  assign m_aw_addr  = aw_cur_q;
  assign m_aw_len   = 8'd0;
  assign m_aw_size  = aw_size_q;
  assign m_aw_burst = aw_burst_q;
  assign m_aw_atop  = (w_cnt == 8'd0) ? aw_atop_q : 6'd0;
  assign m_aw_attr  = aw_attr_q;
  assign m_w_data   = s_w_data;
  assign m_w_strb   = s_w_strb;
  assign m_w_last   = 1'b1;
  assign s_b_id     = aw_id_q;
  assign s_b_resp   = w_acc;

  always_comb begin
    r_next     = r_state;
    s_ar_ready = 1'b0;
    m_ar_valid = 1'b0;
    s_r_valid  = 1'b0;
    m_r_ready  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_ar_ready = 1'b1;
        if (s_ar_valid) r_next = R_ADDR;
      end
      R_ADDR: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) r_next = R_DATA;
      end
      R_DATA: begin
        s_r_valid = m_r_valid;
        m_r_ready = s_r_ready;
        if (m_r_valid && s_r_ready) begin
          r_next = r_last_beat ? R_IDLE : R_ADDR;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= R_IDLE;
      ar_id_q    <= '0;
      ar_cur_q   <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_attr_q  <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= r_next;
      if (s_ar_valid && s_ar_ready) begin
        ar_id_q    <= s_ar_id;
        ar_cur_q   <= s_ar_addr;
        ar_len_q   <= s_ar_len;
        ar_size_q  <= s_ar_size;
        ar_burst_q <= s_ar_burst;
        ar_attr_q  <= s_ar_attr;
        r_cnt      <= '0;
      end
      if (s_r_valid && s_r_ready && !r_last_beat) begin
        r_cnt    <= r_cnt + 8'd1;
        ar_cur_q <= next_addr(ar_cur_q, ar_len_q, ar_size_q, ar_burst_q);
      end
    end
  end

  assign m_ar_id    = ar_id_q;
  assign m_ar_addr  = ar_cur_q;
  assign m_ar_len   = 8'd0;
  assign m_ar_size  = ar_size_q;
  assign m_ar_burst = ar_burst_q;
  assign m_ar_attr  = ar_attr_q;
  assign s_r_id     = ar_id_q;
  assign s_r_data   = m_r_data;
  assign s_r_resp   = m_r_resp;
  assign s_r_last   = r_last_beat;

endmodule
